image_pixel_server: RTL and testbench

- Memory-side responder for the masked 2D filter's pixel-read interface.
- Holds one H x W frame of INPUT_SIZE-bit pixels, loaded in raster order through a valid/ready stream.
- Serves the filter's pipelined (row, col) read requests with fixed 1-cycle latency.
- Coordinates outside the frame return padding, so the filter can sweep an n x n window across image borders.

---
 rtl/image_pixel_server_if.sv | 35 +++
 rtl/image_pixel_server.sv | 152 +++++++++++++++
 tb/tb_image_pixel_server.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/image_pixel_server_if.sv
// image_pixel_server_if
//   Bundles the frame-configuration, pixel-load and pixel-read signals of the
//   image pixel server.
//   master : filter / loader side (drives config, load beats, read requests)
//   slave  : server side (drives handshakes and read responses)
interface image_pixel_server_if #(
    parameter int WORD       = 32,
    parameter int INPUT_SIZE = 8
);
    logic [WORD-1:0]       h;
    logic [WORD-1:0]       w;
    logic                  new_frame;
    logic                  ld_valid;
    logic [INPUT_SIZE-1:0] ld_data;
    logic                  ld_ready;
    logic                  loaded;
    logic                  cfg_err;
    logic                  rd_req;
    logic [WORD-1:0]       rd_row;
    logic [WORD-1:0]       rd_col;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [INPUT_SIZE-1:0] rd_data;
    logic                  rd_pad;

    modport master (
        output h, w, new_frame, ld_valid, ld_data, rd_req, rd_row, rd_col,
        input  ld_ready, loaded, cfg_err, rd_ready, rd_valid, rd_data, rd_pad
    );

    modport slave (
        input  h, w, new_frame, ld_valid, ld_data, rd_req, rd_row, rd_col,
        output ld_ready, loaded, cfg_err, rd_ready, rd_valid, rd_data, rd_pad
    );
endinterface

// File: rtl/image_pixel_server.sv
// image_pixel_server
//   Frame store for the masked 2D filter. Loads one h x w frame in raster
//   order, then answers signed (row, col) read requests one cycle later.
//   Out-of-frame coordinates return padding (rd_pad=1).
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : image_pixel_server_if.slave (config, load stream, read port)
//   Build option:
//     REPLICATE_PAD_EN : when defined, out-of-frame coordinates are clamped to
//                        the nearest edge pixel instead of returning zero.
//
//   state | meaning
//   CFG   | latch h/w, check legality
//   LOAD  | accept pixels in raster order
//   SERVE | frame complete, answer read requests
//   ERR   | illegal h/w, wait for new_frame
module image_pixel_server #(
    parameter int WORD       = 32,
    parameter int INPUT_SIZE = 8,
    parameter int MAX_H      = 64,
    parameter int MAX_W      = 64,
    parameter int ADDR_BITS  = $clog2(MAX_H*MAX_W)
) (
    input logic                 clk,
    input logic                 rst,
    image_pixel_server_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] ST_CFG   = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WORD-1:0]       h_q, h_d;
    logic [WORD-1:0]       w_q, w_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  rd_valid_q;
    logic [INPUT_SIZE-1:0] rd_data_q;
    logic                  rd_pad_q;

    logic [INPUT_SIZE-1:0] mem [DEPTH];

    logic                  ld_acc;
    logic                  rd_acc;
    logic [WORD-1:0]       frame_last;
    logic                  cfg_bad;
    logic                  row_ok, col_ok, in_range;
    logic [WORD-1:0]       row_eff, col_eff;
    logic [ADDR_BITS-1:0]  rd_addr;

    assign bus.ld_ready = (state_q == ST_LOAD);
    assign bus.loaded   = (state_q == ST_SERVE);
    assign bus.rd_ready = (state_q == ST_SERVE);
    assign bus.cfg_err  = (state_q == ST_ERR);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_pad   = rd_pad_q;

    assign ld_acc     = bus.ld_valid && (state_q == ST_LOAD);
    // A request coinciding with new_frame is dropped.
    assign rd_acc     = bus.rd_req && (state_q == ST_SERVE) && !bus.new_frame;
    assign frame_last = h_q * w_q - WORD'(1);
    assign cfg_bad    = (bus.h == '0) || (bus.w == '0) ||
                        (bus.h > WORD'(MAX_H)) || (bus.w > WORD'(MAX_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        w_d     = w_q;
        case (state_q)
            ST_CFG: begin
                h_d     = bus.h;
                w_d     = bus.w;
                cnt_d   = '0;
                state_d = cfg_bad ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
                if (ld_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (WORD'(cnt_q) == frame_last) state_d = ST_SERVE;
                end
            end
            default: ;
        endcase
        if (bus.new_frame && state_q != ST_CFG) begin
            state_d = ST_CFG;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CFG;
            cnt_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            w_q     <= w_d;
        end
    end

    // Coordinates are signed; h_q/w_q are bounded by MAX_H/MAX_W so their
    // signed view is always positive.
    assign row_ok   = ($signed(bus.rd_row) >= 0) && ($signed(bus.rd_row) < $signed(h_q));
    assign col_ok   = ($signed(bus.rd_col) >= 0) && ($signed(bus.rd_col) < $signed(w_q));
    assign in_range = row_ok && col_ok;

`ifdef REPLICATE_PAD_EN
    always_comb begin
        if ($signed(bus.rd_row) < 0)                row_eff = '0;
        else if ($signed(bus.rd_row) >= $signed(h_q)) row_eff = h_q - WORD'(1);
        else                                        row_eff = bus.rd_row;
        if ($signed(bus.rd_col) < 0)                col_eff = '0;
        else if ($signed(bus.rd_col) >= $signed(w_q)) col_eff = w_q - WORD'(1);
        else                                        col_eff = bus.rd_col;
    end
`else
    // Address is don't-care when out of range; the response is forced to 0.
    assign row_eff = bus.rd_row;
    assign col_eff = bus.rd_col;
`endif

    assign rd_addr = ADDR_BITS'(row_eff * w_q + col_eff);

    always_ff @(posedge clk) begin
        if (ld_acc) mem[cnt_q] <= bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_pad_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_pad_q <= !in_range;
`ifdef REPLICATE_PAD_EN
                rd_data_q <= mem[rd_addr];
`else
                rd_data_q <= in_range ? mem[rd_addr] : '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_image_pixel_server.sv
module tb_image_pixel_server;
    localparam int WORD = 32;
    localparam int INPUT_SIZE = 8;
    localparam int MAX_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    image_pixel_server_if #(.WORD(WORD), .INPUT_SIZE(INPUT_SIZE)) bus ();

    image_pixel_server #(.WORD(WORD), .INPUT_SIZE(INPUT_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n pixels (i or 255-i), optionally with ld_valid on every other
    // cycle, counting beats accepted via ld_valid & ld_ready.
    task automatic load_px(input int n, input bit inv, input bit gaps, input bit expect_done);
        int i = 0;
        int c = 0;
        bit acc;
        while (i < n && c < 2*n + 20) begin
            bus.ld_valid = gaps ? (c % 2 == 0) : 1'b1;
            bus.ld_data  = inv ? 8'(255 - i) : 8'(i % 256);
            if (expect_done && i == n-1 && bus.ld_valid) chk("loaded_early", bus.loaded, 0);
            acc = bus.ld_valid && bus.ld_ready;
            tick();
            if (acc) i++;
            c++;
        end
        bus.ld_valid = 1'b0;
        chk("ld_beats", i, n);
        if (expect_done) begin
            chk("loaded", bus.loaded, 1);
            chk("rd_ready", bus.rd_ready, 1);
            chk("ld_ready_after", bus.ld_ready, 0);
        end else begin
            chk("loaded_partial", bus.loaded, 0);
        end
    endtask

    task automatic rd_one(input int row, input int col, input int exp_d, input bit exp_p);
        bus.rd_req = 1'b1;
        bus.rd_row = 32'(row);
        bus.rd_col = 32'(col);
        tick();
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_data", bus.rd_data, exp_d);
        chk("rd_pad", bus.rd_pad, exp_p);
    endtask

    task automatic rd_idle(input int hold_d);
        bus.rd_req = 1'b0;
        tick();
        chk("rd_valid_idle", bus.rd_valid, 0);
        chk("rd_data_hold", bus.rd_data, hold_d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.h = 15; bus.w = 10; bus.new_frame = 0;
        bus.ld_valid = 0; bus.ld_data = 0;
        bus.rd_req = 0; bus.rd_row = 0; bus.rd_col = 0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_loaded", bus.loaded, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_pad", bus.rd_pad, 0);

        rst = 1'b0;
        tick();
        chk("load_ld_ready", bus.ld_ready, 1);
        chk("load_cfg_err", bus.cfg_err, 0);
        load_px(150, 0, 0, 1);

        rd_one(0, 0, 0, 0);
        rd_one(14, 9, 149, 0);
        rd_one(3, 7, 37, 0);
`ifdef REPLICATE_PAD_EN
        rd_one(-1, 0, 0, 1);
        rd_one(0, 10, 9, 1);
        rd_one(15, 3, 143, 1);
        rd_idle(143);
`else
        rd_one(-1, 0, 0, 1);
        rd_one(0, 10, 0, 1);
        rd_one(15, 3, 0, 1);
        rd_idle(0);
`endif

        // illegal h=0
        bus.new_frame = 1; bus.h = 0; bus.w = 10;
        tick();
        bus.new_frame = 0;
        tick();
        chk("err_h0", bus.cfg_err, 1);
        chk("err_ld_ready", bus.ld_ready, 0);
        chk("err_rd_ready", bus.rd_ready, 0);
        chk("err_loaded", bus.loaded, 0);
        bus.rd_req = 1;
        tick();
        chk("err_rd_valid", bus.rd_valid, 0);
        bus.rd_req = 0;

        // illegal w=MAX_W+1
        bus.new_frame = 1; bus.h = 4; bus.w = MAX_W + 1;
        tick();
        bus.new_frame = 0;
        tick();
        chk("err_wmax", bus.cfg_err, 1);

        // legal 4x4
        bus.new_frame = 1; bus.w = 4;
        tick();
        bus.new_frame = 0;
        chk("cfg_err_clear", bus.cfg_err, 0);
        tick();
        chk("load4_ld_ready", bus.ld_ready, 1);
        load_px(16, 0, 0, 1);
        rd_one(3, 3, 15, 0);
        rd_one(-1, -1, 0, 1);
        rd_idle(0);

        // request in the new_frame cycle is dropped
        bus.rd_req = 1; bus.rd_row = 0; bus.rd_col = 0;
        bus.new_frame = 1; bus.h = 15; bus.w = 10;
        tick();
        bus.rd_req = 0; bus.new_frame = 0;
        chk("drop_rd_valid", bus.rd_valid, 0);
        chk("drop_loaded", bus.loaded, 0);
        tick();
        load_px(50, 0, 0, 0);
        bus.rd_req = 1; bus.rd_row = 0; bus.rd_col = 0;
        chk("load_rd_ready", bus.rd_ready, 0);
        tick();
        chk("load_rd_valid", bus.rd_valid, 0);
        bus.rd_req = 0;
        bus.new_frame = 1;
        tick();
        bus.new_frame = 0;
        tick();
        load_px(150, 1, 1, 1);
        rd_one(0, 0, 255, 0);
        rd_one(14, 9, 106, 0);
        rd_one(5, 5, 200, 0);
        rd_idle(200);

        // reset in SERVE with a request pending
        bus.rd_req = 1; bus.rd_row = 1; bus.rd_col = 1;
        rst = 1'b1;
        tick();
        bus.rd_req = 0;
        chk("rst2_rd_valid", bus.rd_valid, 0);
        chk("rst2_rd_data", bus.rd_data, 0);
        chk("rst2_rd_pad", bus.rd_pad, 0);
        chk("rst2_loaded", bus.loaded, 0);
        chk("rst2_rd_ready", bus.rd_ready, 0);
        chk("rst2_ld_ready", bus.ld_ready, 0);
        chk("rst2_cfg_err", bus.cfg_err, 0);
        rst = 1'b0;
        tick();
        chk("rst2_to_load", bus.ld_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
